// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset release sequencer: FSM states, width
// helpers and the parameter legality check used at elaboration.
package rst_seq_pkg;

   // Sequencer states.
   typedef enum logic [2:0] {
      SYNC,
      REL,
      GAP,
      RUN,
      HOLD
   } seq_state_t;

   // Down-counter width: must hold the larger of the gap and hold loads.
   function automatic int cnt_width(input int gap_cycles, input int hold_cycles);
      int max_cycles;
      max_cycles = (gap_cycles > hold_cycles) ? gap_cycles : hold_cycles;
      return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
   endfunction

   // Bank index width, never narrower than one bit.
   function automatic int idx_width(input int num_banks);
      return (num_banks < 2) ? 1 : $clog2(num_banks);
   endfunction

   // True when the parameter set respects the supported ranges.
   function automatic bit params_legal(input int num_banks, input int sync_stages,
                                       input int gap_cycles, input int hold_cycles);
      return (num_banks >= 1) && (num_banks <= 16) && (sync_stages >= 2) &&
             (gap_cycles >= 1) && (hold_cycles >= 1);
   endfunction

endpackage

// File: rtl/rst_sync_n.sv
// Async-assert, sync-release reset synchronizer. The output drops at once
// when rn falls and rises on the STAGES-th rising clk edge after rn rises.
module rst_sync_n #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rn,
   output logic rn_sync
);

   logic [STAGES-1:0] sync_q;

   // Shift a constant one through the chain; rn clears every stage at once.
   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples its neighbour's pre-edge value and the chain really shifts.
   always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], 1'b1};
      end
   end

   assign rn_sync = sync_q[STAGES-1];

endmodule

// File: rtl/rst_release_seq.sv
// Reset release sequencer: asserts all bank resets immediately on RN,
// releases them one at a time GAP_CYCLES apart after RN is synchronized,
// and re-runs the release on a four-phase software reset handshake.
module rst_release_seq
   import rst_seq_pkg::*;
#(
   parameter int NUM_BANKS   = 4,
   parameter int SYNC_STAGES = 2,
   parameter int GAP_CYCLES  = 8,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                 CLK,
   input  logic                 RN,
   input  logic                 SW_RST_REQ,
   output logic                 SW_RST_ACK,
   output logic [NUM_BANKS-1:0] BANK_RN,
   output logic                 DONE,
   output logic                 BUSY
);

   localparam int CNT_W = cnt_width(GAP_CYCLES, HOLD_CYCLES);
   localparam int IDX_W = idx_width(NUM_BANKS);

   localparam logic [CNT_W-1:0]     GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0]     HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_BANKS - 1);
   localparam logic [NUM_BANKS-1:0] ONE_BANK  = NUM_BANKS'(1);

   if (!params_legal(NUM_BANKS, SYNC_STAGES, GAP_CYCLES, HOLD_CYCLES)) begin : g_param_check
      $error("rst_release_seq: parameter set out of supported range");
   end

   seq_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] nxt_idx;
   logic             sw_seq;
   logic             rn_sync;

   // The raw RN only reaches async clear pins; the FSM sees it through here.
   rst_sync_n #(
      .STAGES (SYNC_STAGES)
   ) u_rst_sync (
      .clk     (CLK),
      .rn      (RN),
      .rn_sync (rn_sync)
   );

   assign nxt_idx = idx + 1'b1;

   // Sequencer FSM with registered outputs. The cycle in SYNC where rn_sync
   // is already high plays the role of the first REL cycle, so bank 0 rises
   // one edge after T0; later banks are released straight from GAP so the
   // bank-to-bank and last-bank-to-DONE spacings are both GAP_CYCLES.
   // NOTE: every flop, outputs included, clears on RN so nothing can be
   // high while the chip reset is asserted; BUSY is the one preset bit.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state      <= SYNC;
         cnt        <= '0;
         idx        <= '0;
         sw_seq     <= 1'b0;
         BANK_RN    <= '0;
         DONE       <= 1'b0;
         BUSY       <= 1'b1;
         SW_RST_ACK <= 1'b0;
      end else begin
         case (state)
            SYNC: begin
               if (rn_sync) begin
                  idx     <= '0;
                  BANK_RN <= BANK_RN | ONE_BANK;
                  cnt     <= GAP_LOAD;
                  state   <= GAP;
               end
            end
            REL: begin
               BANK_RN <= BANK_RN | (ONE_BANK << idx);
               cnt     <= GAP_LOAD;
               state   <= GAP;
            end
            GAP: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (idx == LAST_IDX) begin
                  DONE       <= 1'b1;
                  BUSY       <= 1'b0;
                  SW_RST_ACK <= sw_seq;
                  sw_seq     <= 1'b0;
                  state      <= RUN;
               end else begin
                  idx     <= nxt_idx;
                  BANK_RN <= BANK_RN | (ONE_BANK << nxt_idx);
                  cnt     <= GAP_LOAD;
               end
            end
            RUN: begin
               if (SW_RST_ACK) begin
                  if (!SW_RST_REQ) begin
                     SW_RST_ACK <= 1'b0;
                  end
               end else if (SW_RST_REQ) begin
                  BANK_RN <= '0;
                  DONE    <= 1'b0;
                  BUSY    <= 1'b1;
                  sw_seq  <= 1'b1;
                  cnt     <= HOLD_LOAD;
                  state   <= HOLD;
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  idx   <= '0;
                  state <= REL;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= SYNC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rst_release_seq.sv
// Directed bench for rst_release_seq: power-on release, async re-assertion,
// requests raised mid-sequence, software reset and the REQ/ACK handshake,
// plus a single-bank, unit-gap, three-stage instance.
module tb_rst_release_seq;

   logic       clk = 1'b0;
   logic       rn;
   logic       req;
   logic       req1;
   logic       ack;
   logic [3:0] bank;
   logic       done;
   logic       busy;
   logic       ack1;
   logic [0:0] bank1;
   logic       done1;
   logic       busy1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rst_release_seq #(
      .NUM_BANKS   (4),
      .SYNC_STAGES (2),
      .GAP_CYCLES  (8),
      .HOLD_CYCLES (4)
   ) dut (
      .CLK        (clk),
      .RN         (rn),
      .SW_RST_REQ (req),
      .SW_RST_ACK (ack),
      .BANK_RN    (bank),
      .DONE       (done),
      .BUSY       (busy)
   );

   rst_release_seq #(
      .NUM_BANKS   (1),
      .SYNC_STAGES (3),
      .GAP_CYCLES  (1),
      .HOLD_CYCLES (4)
   ) dut1 (
      .CLK        (clk),
      .RN         (rn),
      .SW_RST_REQ (req1),
      .SW_RST_ACK (ack1),
      .BANK_RN    (bank1),
      .DONE       (done1),
      .BUSY       (busy1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bank k is expected high from edge first + 8*k onwards.
   function automatic logic [3:0] exp_banks(input int e, input int first);
      logic [3:0] m;
      m = '0;
      for (int k = 0; k < 4; k++) begin
         if (e >= first + 8 * k) m[k] = 1'b1;
      end
      return m;
   endfunction

   // Edge-by-edge check of a software-initiated sequence; the accept edge
   // has just been sampled and REQ is still high, so ACK rises with DONE.
   task automatic sw_seq_check(input string tag);
      for (int j = 1; j <= 38; j++) begin
         step();
         check($sformatf("%s j=%0d bank", tag, j), 32'(bank), 32'(exp_banks(j, 5)));
         check($sformatf("%s j=%0d done", tag, j), 32'(done), 32'(j >= 37));
         check($sformatf("%s j=%0d busy", tag, j), 32'(busy), 32'(j < 37));
         check($sformatf("%s j=%0d ack", tag, j), 32'(ack), 32'(j >= 37));
      end
   endtask

   initial begin
      rn   = 1'b1;
      req  = 1'b0;
      req1 = 1'b0;
      #2 rn = 1'b0;

      // Reset state while RN is held low.
      repeat (5) step();
      check("rst bank", 32'(bank), 32'h0);
      check("rst done", 32'(done), 32'h0);
      check("rst busy", 32'(busy), 32'h1);
      check("rst ack", 32'(ack), 32'h0);
      check("rst bank1", 32'(bank1), 32'h0);
      check("rst done1", 32'(done1), 32'h0);
      check("rst busy1", 32'(busy1), 32'h1);
      check("rst ack1", 32'(ack1), 32'h0);

      // Power-on release, interrupted at T0+20 (edge 22 after RN rises).
      #2 rn = 1'b1;
      for (int e = 1; e <= 22; e++) begin
         step();
         check($sformatf("po e=%0d bank", e), 32'(bank), 32'(exp_banks(e, 3)));
         check($sformatf("po e=%0d done", e), 32'(done), 32'(e >= 35));
         check($sformatf("po e=%0d busy", e), 32'(busy), 32'(e < 35));
         check($sformatf("po e=%0d bank1", e), 32'(bank1), 32'(e >= 4));
         check($sformatf("po e=%0d done1", e), 32'(done1), 32'(e >= 5));
      end
      check("po mid bank", 32'(bank), 32'h7);

      // Async assertion between edges clears everything before the next edge.
      #2 rn = 1'b0;
      #1;
      check("async bank", 32'(bank), 32'h0);
      check("async done", 32'(done), 32'h0);
      check("async busy", 32'(busy), 32'h1);
      repeat (3) step();
      check("async held bank", 32'(bank), 32'h0);

      // Full sequence again; REQ raised at T0+5 must wait for RUN.
      #2 rn = 1'b1;
      for (int e = 1; e <= 35; e++) begin
         step();
         check($sformatf("re e=%0d bank", e), 32'(bank), 32'(exp_banks(e, 3)));
         check($sformatf("re e=%0d done", e), 32'(done), 32'(e >= 35));
         check($sformatf("re e=%0d busy", e), 32'(busy), 32'(e < 35));
         check($sformatf("re e=%0d ack", e), 32'(ack), 32'h0);
         if (e == 7) req = 1'b1;
      end

      // First RUN cycle accepts the pending request.
      step();
      check("acc bank", 32'(bank), 32'h0);
      check("acc done", 32'(done), 32'h0);
      check("acc busy", 32'(busy), 32'h1);
      check("acc ack", 32'(ack), 32'h0);
      sw_seq_check("sw1");

      // REQ kept high with ACK up: no second reset.
      for (int c = 0; c < 20; c++) begin
         step();
         check($sformatf("hold c=%0d bank", c), 32'(bank), 32'hf);
         check($sformatf("hold c=%0d ack", c), 32'(ack), 32'h1);
      end

      // Drop REQ: ACK falls on the next edge; banks untouched.
      #2 req = 1'b0;
      step();
      check("drop ack", 32'(ack), 32'h0);
      check("drop bank", 32'(bank), 32'hf);
      check("drop done", 32'(done), 32'h1);

      // New request accepted on the next edge and the sequence repeats.
      #2 req = 1'b1;
      step();
      check("acc2 bank", 32'(bank), 32'h0);
      check("acc2 done", 32'(done), 32'h0);
      sw_seq_check("sw2");
      #2 req = 1'b0;
      step();
      check("end ack", 32'(ack), 32'h0);
      check("end done", 32'(done), 32'h1);
      check("end bank", 32'(bank), 32'hf);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
